// File: rtl/bht_pht_predictor_if.sv
// Predictor-side bundle shared with the pipelined MIPS datapath.
// master: datapath side (drives PCs, instruction, pipeline control, outcome)
// slave : predictor side (returns decode, prediction and misprediction flags)
interface bht_pht_predictor_if;
  logic [31:0] pcF;
  logic [31:0] instrD;
  logic        stallD;
  logic        flushD;
  logic        flushE;
  logic [31:0] pcM;
  logic        actual_takeM;
  logic        branchD;
  logic        pred_takeD;
  logic        branchM;
  logic        pred_takeM;
  logic        mispredM;

  modport master (
    output pcF, instrD, stallD, flushD, flushE, pcM, actual_takeM,
    input  branchD, pred_takeD, branchM, pred_takeM, mispredM
  );

  modport slave (
    input  pcF, instrD, stallD, flushD, flushE, pcM, actual_takeM,
    output branchD, pred_takeD, branchM, pred_takeM, mispredM
  );
endinterface

// File: rtl/bht_pht_predictor.sv
// Two-level branch predictor: per-PC local history (BHT) indexes, XORed with
// PC bits, a table of 2-bit saturating counters (PHT). Lookup in F, prediction
// visible in D, metadata carried to M where the tables are trained.
// Optional build macro BP_GSHARE_EN: replaces the BHT with one global history
// register (gshare); BHT_IDX_W is then unused.
module bht_pht_predictor #(
  parameter int BHT_IDX_W = 6,
  parameter int HIST_W    = 6
) (
  input logic clk,
  input logic rst,
  bht_pht_predictor_if.slave bp
);

  localparam int PHT_N = 1 << HIST_W;

  logic [1:0] pht_q [PHT_N];
  logic [1:0] pht_d [PHT_N];

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;
`else
  localparam int BHT_N = 1 << BHT_IDX_W;
  logic [HIST_W-1:0]    bht_q [BHT_N];
  logic [HIST_W-1:0]    bht_d [BHT_N];
  logic [BHT_IDX_W-1:0] bht_idxF, bht_idxM;
`endif

  logic [HIST_W-1:0] histF, histM, phtidxF;
  logic              predF;
  logic [5:0]        opcodeD;
  logic [4:0]        rtD;
  logic              branch_dec;
  logic              pred_takeD_int;

  logic              predD_q, predD_d;
  logic [HIST_W-1:0] phtidxD_q, phtidxD_d;
  logic              branchE_q, branchE_d;
  logic              pred_takeE_q, pred_takeE_d;
  logic [HIST_W-1:0] phtidxE_q, phtidxE_d;
  logic              branchM_q, branchM_d;
  logic              pred_takeM_q, pred_takeM_d;
  logic [HIST_W-1:0] phtidxM_q, phtidxM_d;

  // Only a slice of each PC and instruction is meaningful here.
  logic unused_bits;
  assign unused_bits = ^{bp.pcF, bp.pcM, bp.instrD};

  // History source for the F lookup and for M training.
`ifdef BP_GSHARE_EN
  always_comb begin
    histF = ghr_q;
    histM = ghr_q;
  end
`else
  always_comb begin
    bht_idxF = bp.pcF[BHT_IDX_W+1:2];
    bht_idxM = bp.pcM[BHT_IDX_W+1:2];
    histF    = bht_q[bht_idxF];
    histM    = bht_q[bht_idxM];
  end
`endif

  // F lookup: history hashed with PC, counter MSB is the prediction.
  always_comb begin
    phtidxF = histF ^ bp.pcF[HIST_W+1:2];
    predF   = pht_q[phtidxF][1];
  end

  // Conditional-branch decode; regimm links (rt[4]=1) and jumps excluded.
  always_comb begin
    opcodeD    = bp.instrD[31:26];
    rtD        = bp.instrD[20:16];
    branch_dec = 1'b0;
    case (opcodeD)
      6'b000100, 6'b000101, 6'b000110, 6'b000111: branch_dec = 1'b1;
      6'b000001: branch_dec = (rtD[4:1] == 4'b0000);
      default:   branch_dec = 1'b0;
    endcase
    pred_takeD_int = branch_dec & predD_q;
  end

  // Metadata pipeline F->D->E->M; flushD beats stallD.
  always_comb begin
    predD_d   = predD_q;
    phtidxD_d = phtidxD_q;
    if (bp.flushD) begin
      predD_d   = 1'b0;
      phtidxD_d = '0;
    end else if (!bp.stallD) begin
      predD_d   = predF;
      phtidxD_d = phtidxF;
    end

    branchE_d    = branch_dec;
    pred_takeE_d = pred_takeD_int;
    phtidxE_d    = phtidxD_q;
    if (bp.flushE) begin
      branchE_d    = 1'b0;
      pred_takeE_d = 1'b0;
      phtidxE_d    = '0;
    end

    branchM_d    = branchE_q;
    pred_takeM_d = pred_takeE_q;
    phtidxM_d    = phtidxE_q;
  end

  // Training at M: shift outcome into history, saturate the carried counter.
  always_comb begin
    pht_d = pht_q;
`ifdef BP_GSHARE_EN
    ghr_d = ghr_q;
`else
    bht_d = bht_q;
`endif
    if (branchM_q) begin
`ifdef BP_GSHARE_EN
      ghr_d = {histM[HIST_W-2:0], bp.actual_takeM};
`else
      bht_d[bht_idxM] = {histM[HIST_W-2:0], bp.actual_takeM};
`endif
      if (bp.actual_takeM && pht_q[phtidxM_q] != 2'b11)
        pht_d[phtidxM_q] = pht_q[phtidxM_q] + 2'b01;
      else if (!bp.actual_takeM && pht_q[phtidxM_q] != 2'b00)
        pht_d[phtidxM_q] = pht_q[phtidxM_q] - 2'b01;
    end
  end

  // Table state; counters reset to weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
`ifdef BP_GSHARE_EN
      ghr_q <= '0;
`else
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= '0;
`endif
    end else begin
      pht_q <= pht_d;
`ifdef BP_GSHARE_EN
      ghr_q <= ghr_d;
`else
      bht_q <= bht_d;
`endif
    end
  end

  // Pipeline metadata registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      predD_q      <= 1'b0;
      phtidxD_q    <= '0;
      branchE_q    <= 1'b0;
      pred_takeE_q <= 1'b0;
      phtidxE_q    <= '0;
      branchM_q    <= 1'b0;
      pred_takeM_q <= 1'b0;
      phtidxM_q    <= '0;
    end else begin
      predD_q      <= predD_d;
      phtidxD_q    <= phtidxD_d;
      branchE_q    <= branchE_d;
      pred_takeE_q <= pred_takeE_d;
      phtidxE_q    <= phtidxE_d;
      branchM_q    <= branchM_d;
      pred_takeM_q <= pred_takeM_d;
      phtidxM_q    <= phtidxM_d;
    end
  end

  // Outputs.
  always_comb begin
    bp.branchD    = branch_dec;
    bp.pred_takeD = pred_takeD_int;
    bp.branchM    = branchM_q;
    bp.pred_takeM = pred_takeM_q;
    bp.mispredM   = branchM_q & (pred_takeM_q != bp.actual_takeM);
  end

endmodule

// File: tb/tb_bht_pht_predictor.sv
// Directed bench for the local-history (default) build of bht_pht_predictor.
module tb_bht_pht_predictor;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  localparam logic [31:0] PC10   = 32'h0040_0010;
  localparam logic [31:0] PC20   = 32'h0040_0020;
  localparam logic [31:0] I_BEQ  = 32'h1085_0003;
  localparam logic [31:0] I_ADD  = 32'h0085_1020;
  localparam logic [31:0] I_J    = 32'h0810_0004;

  bht_pht_predictor_if bp ();

  bht_pht_predictor #(.BHT_IDX_W(6), .HIST_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push one instruction through F, D, E, M with nothing else in flight and
  // return what was observed in D and in M.
  task automatic do_branch(input logic [31:0] pc, input logic [31:0] instr,
                           input logic act,
                           output logic o_brD, output logic o_predD,
                           output logic o_brM, output logic o_predM,
                           output logic o_misp);
    @(negedge clk);
    bp.pcF = pc; bp.instrD = 32'h0;
    @(negedge clk);
    bp.instrD = instr; bp.pcF = 32'h0;
    #1;
    o_brD = bp.branchD; o_predD = bp.pred_takeD;
    @(negedge clk);
    bp.instrD = 32'h0;
    @(negedge clk);
    bp.pcM = pc; bp.actual_takeM = act;
    #1;
    o_brM = bp.branchM; o_predM = bp.pred_takeM; o_misp = bp.mispredM;
    @(negedge clk);
    bp.pcM = 32'h0; bp.actual_takeM = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bp.pcF = PC10; bp.instrD = I_BEQ; bp.stallD = 1'b0; bp.flushD = 1'b0;
    bp.flushE = 1'b0; bp.pcM = PC10; bp.actual_takeM = 1'b1;
    #12;
    total_cnt++;
    if (bp.branchD !== 1'b1) $display("FAIL reset_branchD: got %b expected 1", bp.branchD);
    else pass_cnt++;
    total_cnt++;
    if (bp.pred_takeD !== 1'b0) $display("FAIL reset_pred_takeD: got %b expected 0", bp.pred_takeD);
    else pass_cnt++;
    total_cnt++;
    if (bp.branchM !== 1'b0) $display("FAIL reset_branchM: got %b expected 0", bp.branchM);
    else pass_cnt++;
    total_cnt++;
    if (bp.pred_takeM !== 1'b0) $display("FAIL reset_pred_takeM: got %b expected 0", bp.pred_takeM);
    else pass_cnt++;
    total_cnt++;
    if (bp.mispredM !== 1'b0) $display("FAIL reset_mispredM: got %b expected 0", bp.mispredM);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bp.instrD = 32'h0; bp.pcF = 32'h0; bp.pcM = 32'h0; bp.actual_takeM = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_decode();
    logic [31:0] instr [12];
    logic        exp   [12];
    instr = '{32'h1085_0003, 32'h1485_0003, 32'h1880_0003, 32'h1C80_0003,
              32'h0480_0002, 32'h0481_0002, 32'h0490_0002, 32'h0491_0002,
              32'h0085_1020, 32'h0810_0004, 32'h0C10_0004, 32'h0482_0002};
    exp   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      bp.instrD = instr[i];
      #1;
      total_cnt++;
      if (bp.branchD !== exp[i])
        $display("FAIL decode_%0d instr=%h: got %b expected %b", i, instr[i], bp.branchD, exp[i]);
      else pass_cnt++;
    end
    bp.instrD = 32'h0;
    @(negedge clk);
  endtask

  // beq at PC10 taken 11 times. History walks 0,1,3,7,F,1F,3F,3F...; indices
  // 4,5,7,3,B,1B,3B,3B... so only index 3B is revisited: 01->10->11->11->11.
  task automatic test_train_taken();
    logic exp_pred [11];
    logic brD, prD, brM, prM, misp;
    exp_pred = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 11; i++) begin
      do_branch(PC10, I_BEQ, 1'b1, brD, prD, brM, prM, misp);
      total_cnt++;
      if (prD !== exp_pred[i] || brD !== 1'b1)
        $display("FAIL train_predD_%0d: got br=%b pred=%b expected br=1 pred=%b", i, brD, prD, exp_pred[i]);
      else pass_cnt++;
      total_cnt++;
      if (brM !== 1'b1 || prM !== exp_pred[i] || misp !== !exp_pred[i])
        $display("FAIL train_M_%0d: got br=%b pred=%b misp=%b expected br=1 pred=%b misp=%b",
                 i, brM, prM, misp, exp_pred[i], !exp_pred[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_non_branch();
    logic brD, prD, brM, prM, misp;
    do_branch(PC10, I_ADD, 1'b0, brD, prD, brM, prM, misp);
    total_cnt++;
    if (brD !== 1'b0 || prD !== 1'b0 || brM !== 1'b0 || misp !== 1'b0)
      $display("FAIL nonbranch_add: got brD=%b predD=%b brM=%b misp=%b expected all 0", brD, prD, brM, misp);
    else pass_cnt++;
    do_branch(PC10, I_J, 1'b1, brD, prD, brM, prM, misp);
    total_cnt++;
    if (brD !== 1'b0 || prD !== 1'b0 || brM !== 1'b0 || misp !== 1'b0)
      $display("FAIL nonbranch_j: got brD=%b predD=%b brM=%b misp=%b expected all 0", brD, prD, brM, misp);
    else pass_cnt++;
    // Had add trained not-taken, history would be 3E and the prediction 0.
    do_branch(PC10, I_BEQ, 1'b1, brD, prD, brM, prM, misp);
    total_cnt++;
    if (prD !== 1'b1 || misp !== 1'b0)
      $display("FAIL nonbranch_untouched: got pred=%b misp=%b expected pred=1 misp=0", prD, misp);
    else pass_cnt++;
  endtask

  // PC10 predicts taken, PC20 (fresh) predicts not taken. flushE is held so
  // the branch sitting in D never reaches M.
  task automatic test_stall_flush();
    @(negedge clk);
    bp.pcF = PC10; bp.instrD = 32'h0; bp.flushE = 1'b1;
    @(negedge clk);
    bp.instrD = I_BEQ; bp.stallD = 1'b1; bp.pcF = PC20;
    #1;
    total_cnt++;
    if (bp.pred_takeD !== 1'b1) $display("FAIL stall_start: got %b expected 1", bp.pred_takeD);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (bp.pred_takeD !== 1'b1) $display("FAIL stall_hold_%0d: got %b expected 1", i, bp.pred_takeD);
      else pass_cnt++;
    end
    bp.stallD = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if (bp.pred_takeD !== 1'b0) $display("FAIL stall_release: got %b expected 0", bp.pred_takeD);
    else pass_cnt++;
    bp.pcF = PC10;
    @(negedge clk);
    #1;
    total_cnt++;
    if (bp.pred_takeD !== 1'b1) $display("FAIL stall_reload: got %b expected 1", bp.pred_takeD);
    else pass_cnt++;
    bp.flushD = 1'b1; bp.stallD = 1'b1;
    @(negedge clk);
    #1;
    total_cnt++;
    if (bp.pred_takeD !== 1'b0) $display("FAIL flushD_priority: got %b expected 0", bp.pred_takeD);
    else pass_cnt++;
    bp.flushD = 1'b0; bp.stallD = 1'b0; bp.instrD = 32'h0; bp.pcF = 32'h0;
    @(negedge clk);
    bp.flushE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total_cnt++;
    if (bp.branchM !== 1'b0) $display("FAIL stall_no_leak: got branchM=%b expected 0", bp.branchM);
    else pass_cnt++;
  endtask

  task automatic test_flushE();
    logic brD, prD, brM, prM, misp;
    @(negedge clk);
    bp.pcF = PC10; bp.instrD = 32'h0;
    @(negedge clk);
    bp.instrD = I_BEQ; bp.pcF = 32'h0; bp.flushE = 1'b1;
    #1;
    total_cnt++;
    if (bp.pred_takeD !== 1'b1) $display("FAIL flushE_predD: got %b expected 1", bp.pred_takeD);
    else pass_cnt++;
    @(negedge clk);
    bp.instrD = 32'h0; bp.flushE = 1'b0;
    @(negedge clk);
    bp.pcM = PC10; bp.actual_takeM = 1'b0;
    #1;
    total_cnt++;
    if (bp.branchM !== 1'b0 || bp.pred_takeM !== 1'b0 || bp.mispredM !== 1'b0)
      $display("FAIL flushE_M: got br=%b pred=%b misp=%b expected 0 0 0", bp.branchM, bp.pred_takeM, bp.mispredM);
    else pass_cnt++;
    @(negedge clk);
    bp.pcM = 32'h0; bp.actual_takeM = 1'b0;
    do_branch(PC10, I_BEQ, 1'b1, brD, prD, brM, prM, misp);
    total_cnt++;
    if (prD !== 1'b1 || misp !== 1'b0)
      $display("FAIL flushE_untouched: got pred=%b misp=%b expected pred=1 misp=0", prD, misp);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic brD, prD, brM, prM, misp;
    @(negedge clk);
    bp.pcF = PC10; bp.instrD = 32'h0;
    @(negedge clk);
    bp.instrD = I_BEQ; bp.pcF = 32'h0;
    @(negedge clk);
    bp.instrD = 32'h0;
    @(negedge clk);
    bp.pcM = PC10; bp.actual_takeM = 1'b0;
    #1;
    total_cnt++;
    if (bp.mispredM !== 1'b1) $display("FAIL midreset_pre: got misp=%b expected 1", bp.mispredM);
    else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (bp.branchM !== 1'b0 || bp.mispredM !== 1'b0)
      $display("FAIL midreset_async: got br=%b misp=%b expected 0 0", bp.branchM, bp.mispredM);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0; bp.pcM = 32'h0; bp.actual_takeM = 1'b0;
    do_branch(PC10, I_BEQ, 1'b1, brD, prD, brM, prM, misp);
    total_cnt++;
    if (prD !== 1'b0 || misp !== 1'b1)
      $display("FAIL midreset_tables: got pred=%b misp=%b expected pred=0 misp=1", prD, misp);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_decode();
    test_train_taken();
    test_non_branch();
    test_stall_flush();
    test_flushE();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
